// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: access widths, FSM states
// and the IO address-decode value.
package mem_ctrl_pkg;

    localparam logic [1:0] WIDTH_B = 2'd0;
    localparam logic [1:0] WIDTH_H = 2'd1;
    localparam logic [1:0] WIDTH_W = 2'd2;

    localparam logic [1:0] IO_ADDR_HI_DEFAULT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IFETCH = 2'd1,
        ST_LOAD   = 2'd2,
        ST_STORE  = 2'd3
    } state_e;

    // The illegal encoding 3 falls through to a full word.
    function automatic logic [2:0] width_bytes(input logic [1:0] width);
        case (width)
            WIDTH_B: return 3'd1;
            WIDTH_H: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates icache fetches and LSB loads/stores onto one byte-wide RAM/IO
// port, serialising every access into little-endian byte cycles.
//
// state     | meaning
// ST_IDLE   | waiting for a request; LSB wins over icache
// ST_IFETCH | reading 4 bytes for the icache
// ST_LOAD   | reading 1/2/4 bytes for the LSB
// ST_STORE  | writing 1/2/4 bytes, stalling on a full IO buffer
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [1:0] IO_ADDR_HI = IO_ADDR_HI_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic        clear,
    input  logic        icache_to_memctrl,
    input  logic [31:0] icache_addr,
    output logic        received,
    output logic        memctrl_to_icache,
    output logic [31:0] inst_out,
    input  logic        lsb_req,
    input  logic        lsb_we,
    input  logic [1:0]  lsb_width,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_received,
    output logic        lsb_done,
    output logic [31:0] lsb_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    state_e      state;
    logic [2:0]  cnt;
    logic [2:0]  nbytes;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rbuf;

    logic [2:0]  cnt_nx;
    logic [1:0]  byte_idx;
    logic        is_io;

    assign cnt_nx   = cnt + 3'd1;
    // Read byte k arrives one cycle after its address, so it lands while cnt = k+1.
    assign byte_idx = 2'(cnt - 3'd1);
    assign is_io    = (addr_q[17:16] == IO_ADDR_HI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= ST_IDLE;
            cnt               <= 3'd0;
            nbytes            <= 3'd0;
            addr_q            <= 32'd0;
            wdata_q           <= 32'd0;
            rbuf              <= 32'd0;
            received          <= 1'b0;
            memctrl_to_icache <= 1'b0;
            inst_out          <= 32'd0;
            lsb_received      <= 1'b0;
            lsb_done          <= 1'b0;
            lsb_rdata         <= 32'd0;
            mem_dout          <= 8'd0;
            mem_a             <= 32'd0;
            mem_wr            <= 1'b0;
        end else if (rdy) begin
            received          <= 1'b0;
            memctrl_to_icache <= 1'b0;
            lsb_received      <= 1'b0;
            lsb_done          <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt    <= 3'd0;
                    mem_wr <= 1'b0;
                    if (!clear && lsb_req) begin
                        state        <= lsb_we ? ST_STORE : ST_LOAD;
                        lsb_received <= 1'b1;
                        addr_q       <= lsb_addr;
                        wdata_q      <= lsb_wdata;
                        nbytes       <= width_bytes(lsb_width);
                        mem_a        <= lsb_addr;
                        rbuf         <= 32'd0;
                    end else if (!clear && icache_to_memctrl) begin
                        state    <= ST_IFETCH;
                        received <= 1'b1;
                        addr_q   <= icache_addr;
                        nbytes   <= 3'd4;
                        mem_a    <= icache_addr;
                        rbuf     <= 32'd0;
                    end
                end
                ST_IFETCH, ST_LOAD: begin
                    if (clear) begin
                        state <= ST_IDLE;
                        cnt   <= 3'd0;
                    end else if (cnt == nbytes + 3'd1) begin
                        state <= ST_IDLE;
                        cnt   <= 3'd0;
                        if (state == ST_IFETCH) begin
                            memctrl_to_icache <= 1'b1;
                            inst_out          <= rbuf;
                        end else begin
                            lsb_done  <= 1'b1;
                            lsb_rdata <= rbuf;
                        end
                    end else begin
                        cnt <= cnt_nx;
                        if (cnt != 3'd0)
                            rbuf[{byte_idx, 3'b000} +: 8] <= mem_din;
                        if (cnt_nx < nbytes)
                            mem_a <= addr_q + 32'(cnt_nx);
                    end
                end
                ST_STORE: begin
                    // Stores are already committed to memory, so clear is ignored here.
                    if (cnt == nbytes) begin
                        state    <= ST_IDLE;
                        cnt      <= 3'd0;
                        mem_wr   <= 1'b0;
                        mem_a    <= 32'd0;
                        lsb_done <= 1'b1;
                    end else if (is_io && io_buffer_full) begin
                        mem_wr <= 1'b0;
                    end else begin
                        mem_wr   <= 1'b1;
                        mem_a    <= addr_q + 32'(cnt);
                        mem_dout <= wdata_q[{cnt[1:0], 3'b000} +: 8];
                        cnt      <= cnt_nx;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: a byte-array RAM model drives the port, a
// reference memory predicts every load, fetch and write byte.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b1;
    logic        clear = 1'b0;
    logic        icache_to_memctrl = 1'b0;
    logic [31:0] icache_addr = 32'd0;
    logic        received;
    logic        memctrl_to_icache;
    logic [31:0] inst_out;
    logic        lsb_req = 1'b0;
    logic        lsb_we = 1'b0;
    logic [1:0]  lsb_width = 2'd0;
    logic [31:0] lsb_addr = 32'd0;
    logic [31:0] lsb_wdata = 32'd0;
    logic        lsb_received;
    logic        lsb_done;
    logic [31:0] lsb_rdata;
    logic [7:0]  mem_din = 8'd0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;

    mem_ctrl dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .clear(clear),
        .icache_to_memctrl(icache_to_memctrl), .icache_addr(icache_addr),
        .received(received), .memctrl_to_icache(memctrl_to_icache), .inst_out(inst_out),
        .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_width(lsb_width), .lsb_addr(lsb_addr),
        .lsb_wdata(lsb_wdata), .lsb_received(lsb_received), .lsb_done(lsb_done),
        .lsb_rdata(lsb_rdata), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
        .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    localparam int MEM_SIZE = 262144;
    logic [7:0] ram [0:MEM_SIZE-1];
    logic [7:0] ref_mem [0:MEM_SIZE-1];

    // RAM model: one-cycle read latency, paused by rdy like the controller.
    always @(posedge clk) begin
        if (rdy) begin
            mem_din <= ram[mem_a[17:0]];
            if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
        end
    end

    typedef struct { logic [31:0] data; bit is_load; int lat; } exp_t;
    typedef struct { logic [31:0] addr; logic [7:0] data; } wr_t;

    exp_t exp_ic[$];
    exp_t exp_lsb[$];
    wr_t  exp_wr[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit rdy_edge = 1'b1;
    bit mon_en = 1'b0;
    int ic_acc = 0;
    int lsb_acc = 0;
    bit prev_recv = 1'b0;
    bit prev_lrecv = 1'b0;
    exp_t mon_e;
    wr_t  mon_w;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rdy_edge <= rdy;
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, want, $time);
        end
    endfunction

    function automatic void fail_now(string name);
        checks++;
        failures++;
        $display("FAIL %s: got no event expected one at %0t", name, $time);
    endfunction

    function automatic int nbytes_of(logic [1:0] w);
        return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_read(logic [31:0] a, int n);
        logic [31:0] d = 32'd0;
        logic [31:0] ak;
        for (int k = 0; k < n; k++) begin
            ak = a + 32'(k);
            d[8*k +: 8] = ref_mem[ak[17:0]];
        end
        return d;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a pulse or write.
    always @(negedge clk) begin
        if (mon_en && rdy_edge) begin
            if (received) begin
                ic_acc = cyc;
                chk("received_width", 32'(prev_recv), 32'd0);
                chk("received_vs_done", 32'(memctrl_to_icache), 32'd0);
            end
            if (lsb_received) begin
                lsb_acc = cyc;
                chk("lsb_received_width", 32'(prev_lrecv), 32'd0);
                chk("lsb_received_vs_done", 32'(lsb_done), 32'd0);
            end
            if (memctrl_to_icache) begin
                if (exp_ic.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL icache_done: got unexpected pulse expected none at %0t", $time);
                end else begin
                    mon_e = exp_ic.pop_front();
                    chk("inst_out", inst_out, mon_e.data);
                    chk("icache_latency", 32'(cyc - ic_acc), 32'(mon_e.lat));
                end
            end
            if (lsb_done) begin
                if (exp_lsb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL lsb_done: got unexpected pulse expected none at %0t", $time);
                end else begin
                    mon_e = exp_lsb.pop_front();
                    if (mon_e.is_load) chk("lsb_rdata", lsb_rdata, mon_e.data);
                    chk("lsb_latency", 32'(cyc - lsb_acc), 32'(mon_e.lat));
                end
            end
            if (mem_wr) begin
                if (exp_wr.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL mem_write: got unexpected write a=0x%08h expected none", mem_a);
                end else begin
                    mon_w = exp_wr.pop_front();
                    chk("write_addr", mem_a, mon_w.addr);
                    chk("write_data", 32'(mem_dout), 32'(mon_w.data));
                end
            end
            prev_recv  = received;
            prev_lrecv = lsb_received;
        end
    end

    task automatic wait_recv(input bit is_ic, output int waited);
        waited = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (is_ic ? received : lsb_received) begin
                waited = i;
                return;
            end
        end
        fail_now(is_ic ? "received_timeout" : "lsb_received_timeout");
    endtask

    task automatic wait_drain(input bit is_ic, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if ((is_ic ? exp_ic.size() : exp_lsb.size()) == 0) return;
        end
        fail_now(is_ic ? "icache_done_timeout" : "lsb_done_timeout");
        if (is_ic) exp_ic.delete(); else exp_lsb.delete();
    endtask

    task automatic icache_op(input logic [31:0] a, input bit check_steps);
        exp_t e;
        int w;
        e.data = ref_read(a, 4);
        e.is_load = 1'b1;
        e.lat = 6;
        exp_ic.push_back(e);
        icache_addr = a;
        icache_to_memctrl = 1'b1;
        wait_recv(1'b1, w);
        icache_to_memctrl = 1'b0;
        chk("icache_accept_wait", 32'(w), 32'd1);
        if (w > 0 && check_steps) begin
            for (int k = 0; k < 4; k++) begin
                if (k > 0) @(negedge clk);
                chk("fetch_mem_a", mem_a, a + 32'(k));
            end
        end
        wait_drain(1'b1, 20);
    endtask

    task automatic lsb_op(input bit we, input logic [1:0] wd, input logic [31:0] a,
                          input logic [31:0] d, input bit pause, input bit io_stall);
        exp_t e;
        wr_t wr;
        int n;
        int wt;
        logic [31:0] ak;
        n = nbytes_of(wd);
        e.data = 32'd0;
        if (we) begin
            for (int k = 0; k < n; k++) begin
                ak = a + 32'(k);
                wr.addr = ak;
                wr.data = d[8*k +: 8];
                exp_wr.push_back(wr);
                ref_mem[ak[17:0]] = d[8*k +: 8];
            end
            e.is_load = 1'b0;
            e.lat = n + 1;
        end else begin
            e.data = ref_read(a, n);
            e.is_load = 1'b1;
            e.lat = n + 2;
        end
        if (pause) e.lat += 3;
        if (io_stall) e.lat += 4;
        exp_lsb.push_back(e);
        if (io_stall) io_buffer_full = 1'b1;
        lsb_we = we;
        lsb_width = wd;
        lsb_addr = a;
        lsb_wdata = d;
        lsb_req = 1'b1;
        wait_recv(1'b0, wt);
        lsb_req = 1'b0;
        chk("lsb_accept_wait", 32'(wt), 32'd1);
        if (pause) begin
            @(negedge clk);
            rdy = 1'b0;
            repeat (3) @(negedge clk);
            rdy = 1'b1;
        end
        if (io_stall) begin
            chk("io_stall_no_write", 32'(mem_wr), 32'd0);
            for (int i = 1; i <= 4; i++) begin
                @(negedge clk);
                chk("io_stall_no_write", 32'(mem_wr), 32'd0);
                if (i == 2) clear = 1'b1;
                if (i == 3) clear = 1'b0;
            end
            io_buffer_full = 1'b0;
        end
        wait_drain(1'b0, 30);
    endtask

    initial begin
        logic [7:0] v;
        logic [31:0] ra;
        int lacc;
        int iacc;
        int w;
        bit seen;

        for (int i = 0; i < MEM_SIZE; i++) begin
            v = 8'($urandom);
            ram[i] = v;
            ref_mem[i] = v;
        end
        ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
        ref_mem[32'h100] = 8'h13; ref_mem[32'h101] = 8'h05; ref_mem[32'h102] = 8'h00; ref_mem[32'h103] = 8'h00;
        ram[32'h20] = 8'hFF;
        ref_mem[32'h20] = 8'hFF;

        // Reset values
        repeat (3) @(negedge clk);
        chk("reset_received", 32'(received), 32'd0);
        chk("reset_icache_done", 32'(memctrl_to_icache), 32'd0);
        chk("reset_inst_out", inst_out, 32'd0);
        chk("reset_lsb_pulses", 32'({lsb_received, lsb_done}), 32'd0);
        chk("reset_lsb_rdata", lsb_rdata, 32'd0);
        chk("reset_mem_a", mem_a, 32'd0);
        chk("reset_mem_wr_dout", 32'({mem_wr, mem_dout}), 32'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // icache fetch of 0x00000513
        icache_op(32'h100, 1'b1);

        // Contention: LSB byte load and icache fetch in the same cycle
        begin
            exp_t e;
            e.data = ref_read(32'h20, 1); e.is_load = 1'b1; e.lat = 3;
            exp_lsb.push_back(e);
            e.data = ref_read(32'h300, 4); e.is_load = 1'b1; e.lat = 6;
            exp_ic.push_back(e);
            lsb_we = 1'b0; lsb_width = 2'd0; lsb_addr = 32'h20; lsb_req = 1'b1;
            icache_addr = 32'h300; icache_to_memctrl = 1'b1;
            lacc = -1; iacc = -1;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (lsb_received && lacc < 0) begin lacc = cyc; lsb_req = 1'b0; end
                if (received) begin iacc = cyc; icache_to_memctrl = 1'b0; break; end
            end
            icache_to_memctrl = 1'b0;
            lsb_req = 1'b0;
            chk("lsb_accepted", 32'(lacc >= 0), 32'd1);
            chk("icache_after_lsb", 32'(iacc - lacc), 32'd4);
            wait_drain(1'b1, 20);
            wait_drain(1'b0, 5);
        end

        // Half-word store then word load over it
        lsb_op(1'b1, 2'd1, 32'h40, 32'h1234BEEF, 1'b0, 1'b0);
        lsb_op(1'b0, 2'd2, 32'h40, 32'd0, 1'b0, 1'b0);

        // Flush during fetch at cnt = 2
        icache_addr = 32'h180;
        icache_to_memctrl = 1'b1;
        wait_recv(1'b1, w);
        icache_to_memctrl = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("flush_no_done", 32'(memctrl_to_icache), 32'd0);
        icache_op(32'h200, 1'b1);

        // IO stall with clear during the stall
        lsb_op(1'b1, 2'd0, 32'h30000, 32'h000000A5, 1'b0, 1'b1);

        // Pause mid-load
        lsb_op(1'b0, 2'd2, 32'h1234, 32'd0, 1'b1, 1'b0);

        // Address wrap and illegal width
        lsb_op(1'b1, 2'd2, 32'hFFFFFFFF, $urandom, 1'b0, 1'b0);
        lsb_op(1'b0, 2'd2, 32'hFFFFFFFE, 32'd0, 1'b0, 1'b0);
        lsb_op(1'b1, 2'd3, 32'h80, $urandom, 1'b0, 1'b0);
        lsb_op(1'b0, 2'd3, 32'h80, 32'd0, 1'b0, 1'b0);

        // Randomised mix
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                ra[0] = 1'b0;
                icache_op(ra, 1'b1);
            end else begin
                lsb_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ra, $urandom, 1'b0, 1'b0);
            end
        end

        // Asynchronous reset in the middle of a store
        mon_en = 1'b0;
        lsb_we = 1'b1; lsb_width = 2'd2; lsb_addr = 32'h1000; lsb_wdata = 32'hCAFEF00D;
        lsb_req = 1'b1;
        wait_recv(1'b0, w);
        lsb_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_wr) begin seen = 1'b1; break; end
        end
        chk("store_started", 32'(seen), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_mem_wr", 32'(mem_wr), 32'd0);
        chk("async_reset_mem_a", mem_a, 32'd0);
        chk("async_reset_pulses", 32'({received, memctrl_to_icache, lsb_received, lsb_done}), 32'd0);
        chk("async_reset_data", inst_out | lsb_rdata | 32'(mem_dout), 32'd0);
        repeat (2) @(negedge clk);
        chk("reset_held_mem_wr", 32'(mem_wr), 32'd0);
        chk("reset_held_pulses", 32'({received, memctrl_to_icache, lsb_received, lsb_done}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
